// File: rtl/pet_pkg.sv
// Shared encodings for the virtual-pet need engine.
package pet_pkg;

  typedef enum logic [1:0] {
    MOOD_HAPPY    = 2'd0,
    MOOD_NEUTRAL  = 2'd1,
    MOOD_SAD      = 2'd2,
    MOOD_CRITICAL = 2'd3
  } mood_t;

  typedef enum logic [1:0] {
    HOLD_IDLE = 2'd0,
    HOLD_HOLD = 2'd1,
    HOLD_LOCK = 2'd2
  } hold_state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int CFGW        = 6;

endpackage

// File: rtl/need_channel.sv
// One need channel: stimulus hold FSM, decay counter and saturating level register.
module need_channel
  import pet_pkg::*;
#(
  parameter int LVLW    = 3,
  parameter int LVL_MIN = 1,
  parameter int LVL_MAX = 5,
  parameter int LVL_RST = 3,
  parameter int MAX_INC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sec_tick,
  input  logic            min_tick,
  input  logic            stim,
  input  logic [CFGW-1:0] cfg_hold,
  input  logic [CFGW-1:0] cfg_decay,
  output logic [LVLW-1:0] level,
  output logic            inc_pulse
);

  localparam int ICW = (MAX_INC > 1) ? $clog2(MAX_INC + 1) : 1;
  localparam logic [LVLW-1:0] LMIN = LVLW'(LVL_MIN);
  localparam logic [LVLW-1:0] LMAX = LVLW'(LVL_MAX);
  localparam logic [LVLW-1:0] LRST = LVLW'(LVL_RST);
  localparam logic [ICW:0]    IMAX = (ICW + 1)'(MAX_INC);

  hold_state_t state, state_nxt;
  logic [CFGW-1:0] hold_cnt, hold_nxt, dec_cnt, dec_nxt;
  logic [ICW-1:0]  inc_cnt, inc_cnt_nxt;
  logic [CFGW:0]   hold_p1, dec_p1;
  logic [ICW:0]    inc_cnt_p1;
  logic [LVLW-1:0] level_nxt;
  logic            inc_req, dec_req;

  function automatic logic [LVLW-1:0] sat_inc(input logic [LVLW-1:0] v);
    return (v >= LMAX) ? LMAX : v + LVLW'(1);
  endfunction

  function automatic logic [LVLW-1:0] sat_dec(input logic [LVLW-1:0] v);
    return (v <= LMIN) ? LMIN : v - LVLW'(1);
  endfunction

  assign hold_p1    = {1'b0, hold_cnt} + (CFGW + 1)'(1);
  assign dec_p1     = {1'b0, dec_cnt} + (CFGW + 1)'(1);
  assign inc_cnt_p1 = {1'b0, inc_cnt} + (ICW + 1)'(1);

  // Hold FSM: counts real seconds while stim is held; >= tolerates cfg_hold shrinking mid-hold
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    inc_cnt_nxt = inc_cnt;
    inc_req     = 1'b0;
    case (state)
      HOLD_IDLE: begin
        if (stim) begin
          state_nxt   = HOLD_HOLD;
          hold_nxt    = '0;
          inc_cnt_nxt = '0;
        end
      end
      HOLD_HOLD: begin
        if (!stim) begin
          state_nxt = HOLD_IDLE;
        end else if (sec_tick) begin
          if (hold_p1 >= {1'b0, cfg_hold}) begin
            inc_req     = 1'b1;
            hold_nxt    = '0;
            inc_cnt_nxt = inc_cnt_p1[ICW-1:0];
            if (inc_cnt_p1 >= IMAX) state_nxt = HOLD_LOCK;
          end else begin
            hold_nxt = hold_p1[CFGW-1:0];
          end
        end
      end
      HOLD_LOCK: begin
        if (!stim) state_nxt = HOLD_IDLE;
      end
      default: state_nxt = HOLD_IDLE;
    endcase
  end

  always_comb begin
    dec_nxt = dec_cnt;
    dec_req = 1'b0;
    if (cfg_decay == '0) begin
      dec_nxt = '0;
    end else if (min_tick) begin
      if (dec_p1 >= {1'b0, cfg_decay}) begin
        dec_req = 1'b1;
        dec_nxt = '0;
      end else begin
        dec_nxt = dec_p1[CFGW-1:0];
      end
    end
  end

  // Simultaneous increment and decrement cancel out
  always_comb begin
    level_nxt = level;
    if (inc_req && !dec_req)      level_nxt = sat_inc(level);
    else if (dec_req && !inc_req) level_nxt = sat_dec(level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD_IDLE;
      hold_cnt  <= '0;
      inc_cnt   <= '0;
      dec_cnt   <= '0;
      level     <= LRST;
      inc_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      inc_cnt   <= inc_cnt_nxt;
      dec_cnt   <= dec_nxt;
      level     <= level_nxt;
      inc_pulse <= inc_req;
    end
  end

endmodule

// File: rtl/pet_need_engine.sv
// Need-level engine: real-second prescaler, game-minute clock, NCH need channels and mood.
module pet_need_engine
  import pet_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int LVLW       = 3,
  parameter int LVL_MIN    = 1,
  parameter int LVL_MAX    = 5,
  parameter int LVL_RST    = 3,
  parameter int TICK_DIV   = 50_000_000,
  parameter int ACC_FACTOR = 30,
  parameter int MAX_INC    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      stim,
  input  logic                acc,
  input  logic [NCH*6-1:0]    cfg_hold,
  input  logic [NCH*6-1:0]    cfg_decay,
  output logic [NCH*LVLW-1:0] level,
  output logic [NCH-1:0]      inc_pulse,
  output logic [NCH-1:0]      alarm,
  output logic [1:0]          mood
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [LVLW-1:0] LMIN  = LVLW'(LVL_MIN);
  localparam logic [LVLW-1:0] LMIN1 = LVLW'(LVL_MIN + 1);
  localparam logic [LVLW-1:0] LHIGH = LVLW'(LVL_MAX - 1);
  localparam logic [LVLW-1:0] LRST  = LVLW'(LVL_RST);

  logic [PW-1:0] pre_cnt;
  logic [5:0]    game_sec, game_nxt;
  logic [6:0]    game_sum;
  logic          sec_tick, min_tick;
  mood_t         mood_p1;

  function automatic mood_t mood_of(input logic [NCH*LVLW-1:0] lv);
    logic any_min, any_min1, all_high;
    any_min  = 1'b0;
    any_min1 = 1'b0;
    all_high = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (lv[i*LVLW +: LVLW] == LMIN)  any_min  = 1'b1;
      if (lv[i*LVLW +: LVLW] == LMIN1) any_min1 = 1'b1;
      if (lv[i*LVLW +: LVLW] <  LHIGH) all_high = 1'b0;
    end
    if (any_min)       return MOOD_CRITICAL;
    else if (any_min1) return MOOD_SAD;
    else if (all_high) return MOOD_HAPPY;
    else               return MOOD_NEUTRAL;
  endfunction

  assign sec_tick = (pre_cnt == PW'(TICK_DIV - 1));

  // At most one game minute elapses per real second since ACC_FACTOR <= 60
  always_comb begin
    game_sum = {1'b0, game_sec} + (acc ? 7'(ACC_FACTOR) : 7'd1);
    min_tick = sec_tick && (game_sum >= 7'(SEC_PER_MIN));
    game_nxt = min_tick ? 6'(game_sum - 7'(SEC_PER_MIN)) : game_sum[5:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      game_sec <= '0;
    end else begin
      pre_cnt <= sec_tick ? '0 : pre_cnt + PW'(1);
      if (sec_tick) game_sec <= game_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    need_channel #(
      .LVLW    (LVLW),
      .LVL_MIN (LVL_MIN),
      .LVL_MAX (LVL_MAX),
      .LVL_RST (LVL_RST),
      .MAX_INC (MAX_INC)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sec_tick  (sec_tick),
      .min_tick  (min_tick),
      .stim      (stim[i]),
      .cfg_hold  (cfg_hold[i*6 +: 6]),
      .cfg_decay (cfg_decay[i*6 +: 6]),
      .level     (level[i*LVLW +: LVLW]),
      .inc_pulse (inc_pulse[i])
    );
    assign alarm[i] = (level[i*LVLW +: LVLW] == LMIN);
  end

  // Mood stage: one clk behind the level registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mood_p1 <= mood_of({NCH{LRST}});
    else     mood_p1 <= mood_of(level);
  end

  assign mood = mood_p1;

endmodule

// File: tb/tb_pet_need_engine.sv
// Scoreboard bench for pet_need_engine: directed phases push expected level events, a monitor checks them.
module tb_pet_need_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  stim = '0;
  logic        acc = 1'b0;
  logic [23:0] cfg_hold  = {4{6'd3}};
  logic [23:0] cfg_decay = {4{6'd2}};
  logic [11:0] level;
  logic [3:0]  inc_pulse;
  logic [3:0]  alarm;
  logic [1:0]  mood;

  localparam logic [1:0] HAPPY = 2'd0, NEUTRAL = 2'd1, SAD = 2'd2, CRIT = 2'd3;

  pet_need_engine #(
    .NCH(4), .LVLW(3), .LVL_MIN(1), .LVL_MAX(5), .LVL_RST(3),
    .TICK_DIV(4), .ACC_FACTOR(30), .MAX_INC(2)
  ) dut (
    .clk(clk), .rst(rst), .stim(stim), .acc(acc),
    .cfg_hold(cfg_hold), .cfg_decay(cfg_decay),
    .level(level), .inc_pulse(inc_pulse), .alarm(alarm), .mood(mood)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [11:0] level;
    logic [3:0]  inc;
    logic [3:0]  alarm;
    logic [1:0]  mood;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [11:0] l, input logic [3:0] p,
                         input logic [3:0] a, input logic [1:0] m);
    ev_t e;
    e.cyc = c; e.level = l; e.inc = p; e.alarm = a; e.mood = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] s, input logic a);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    rst  = 1'b1;
    stim = s;
    acc  = a;
    @(negedge clk);
    @(negedge clk);
    check("rst_level", level, 12'o3333);
    check("rst_inc_pulse", inc_pulse, 4'b0000);
    check("rst_alarm", alarm, 4'b0000);
    check("rst_mood", mood, NEUTRAL);
    rst = 1'b0;
  endtask

  // Monitor: any level change or inc_pulse is an event that must match the queue head
  logic [11:0] prev_level;
  logic        mood_pend = 1'b0;
  logic [1:0]  mood_exp;
  ev_t         got;

  always @(negedge clk) begin
    if (rst) begin
      prev_level = level;
      mood_pend  = 1'b0;
    end else begin
      if (mood_pend) begin
        check("mood_after_event", mood, mood_exp);
        mood_pend = 1'b0;
      end
      if (level != prev_level || inc_pulse != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: cyc %0d level %o inc_pulse %b, expected no event",
                   cyc, level, inc_pulse);
        end else begin
          got = exp_q.pop_front();
          check("event_cyc", cyc, got.cyc);
          check("event_level", level, got.level);
          check("event_inc_pulse", inc_pulse, got.inc);
          check("event_alarm", alarm, got.alarm);
          mood_pend = 1'b1;
          mood_exp  = got.mood;
        end
      end
      prev_level = level;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hold stim[0]: +1 at 3 s and 6 s, then locked; a 2 s re-hold gives nothing
    do_reset(4'b0001, 1'b0);
    push_ev(12, 12'o3334, 4'b0001, 4'b0000, NEUTRAL);
    push_ev(24, 12'o3335, 4'b0001, 4'b0000, NEUTRAL);
    wait_cyc(40); stim = 4'b0000;
    wait_cyc(44); stim = 4'b0001;
    wait_cyc(54); stim = 4'b0000;
    wait_cyc(60);

    // Real-time decay: one step every 120 s, saturating at 1
    do_reset(4'b0000, 1'b0);
    push_ev(480, 12'o2222, 4'b0000, 4'b0000, SAD);
    push_ev(960, 12'o1111, 4'b0000, 4'b1111, CRIT);
    wait_cyc(1450);

    // Accelerated decay: one step every 4 s
    do_reset(4'b0000, 1'b1);
    push_ev(16, 12'o2222, 4'b0000, 4'b0000, SAD);
    push_ev(32, 12'o1111, 4'b0000, 4'b1111, CRIT);
    wait_cyc(60);

    // Channel 1 increment coincides with the decrement at 16
    do_reset(4'b0000, 1'b1);
    wait_cyc(4); stim = 4'b0010;
    push_ev(16, 12'o2232, 4'b0010, 4'b0000, SAD);
    push_ev(28, 12'o2242, 4'b0010, 4'b0000, SAD);
    push_ev(32, 12'o1131, 4'b0000, 4'b1101, CRIT);
    wait_cyc(34); stim = 4'b0000;
    wait_cyc(40);

    // All channels to 5, then saturated increments still pulse
    do_reset(4'b1111, 1'b0);
    push_ev(12, 12'o4444, 4'b1111, 4'b0000, HAPPY);
    push_ev(24, 12'o5555, 4'b1111, 4'b0000, HAPPY);
    wait_cyc(26); stim = 4'b0000;
    wait_cyc(28); stim = 4'b1111;
    push_ev(40, 12'o5555, 4'b1111, 4'b0000, HAPPY);
    push_ev(52, 12'o5555, 4'b1111, 4'b0000, HAPPY);
    wait_cyc(60);

    // Reset at hold_cnt=2 aborts; a full 3 s hold follows
    do_reset(4'b0100, 1'b0);
    wait_cyc(10);
    do_reset(4'b0100, 1'b0);
    push_ev(12, 12'o3433, 4'b0100, 4'b0000, NEUTRAL);
    wait_cyc(16);
    stim = 4'b0000;
    @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
